// File: rtl/aes_hex_pager.sv
// -----------------------------------------------------------------------------
// aes_hex_pager
// Pages a 128-bit AES value across six hex digit positions. The value is shown
// in eight pages. Each page holds one 16-bit slice (four hex digits), and the
// page index appears in digit position 4. The page changes on a next or prev
// button edge, or on an optional auto-scroll tick.
//
// Parameters
//   TICK_DIV     clk cycles per auto-scroll step (>= 2)
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_load       1-cycle strobe: capture i_data_in and show page 0
//   i_data_in    128-bit value; byte 0 = i_data_in[127:120]
//   i_btn_next   debounced level; a rising edge advances one page
//   i_btn_prev   debounced level; a rising edge goes back one page
//   i_auto_en    level; auto-advance every TICK_DIV cycles
//   o_digits     six nibbles; o_digits[4k+3:4k] drives hex position k
//   o_blank      o_blank[k]=1 turns position k off
//   o_page       current page index 0..7
//   o_valid      set once a value has been loaded since reset
// -----------------------------------------------------------------------------
module aes_hex_pager #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [127:0] i_data_in,
    input  logic         i_btn_next,
    input  logic         i_btn_prev,
    input  logic         i_auto_en,
    output logic [23:0]  o_digits,
    output logic [5:0]   o_blank,
    output logic [2:0]   o_page,
    output logic         o_valid
);

    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRESC_ONE = PW'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_n;
    logic [127:0]   r_data;
    logic [2:0]     r_page;
    logic [PW-1:0]  r_presc;
    logic           r_next_q;
    logic           r_prev_q;
    logic [23:0]    r_digits;
    logic [5:0]     r_blank;
    logic           r_valid;

    logic           w_next_press;
    logic           w_prev_press;
    logic           w_tick;
    logic [127:0]   w_data_n;
    logic [2:0]     w_page_n;
    logic [PW-1:0]  w_presc_n;
    logic [15:0]    w_slice;
    logic [23:0]    w_digits_n;
    logic [5:0]     w_blank_n;
    logic           w_valid_n;

    // A press is the first cycle a button is seen high. Holding a button does not repeat.
    assign w_next_press = i_btn_next & ~r_next_q;
    assign w_prev_press = i_btn_prev & ~r_prev_q;
    // The tick is only meaningful while auto-scrolling in SHOW.
    assign w_tick       = (r_state == ST_SHOW) & i_auto_en & (r_presc == PRESC_TOP);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic: only a reset leaves SHOW
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_state_n = ST_SHOW;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_SHOW: w_state_n = ST_SHOW;
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Page, data and prescaler update.
    // Priority is: load, then both buttons (cancel), then next, then prev, then tick.
    always_comb begin
        w_data_n  = r_data;
        w_page_n  = r_page;
        w_presc_n = '0;
        if (i_load) begin
            w_data_n  = i_data_in;
            w_page_n  = 3'd0;
            w_presc_n = '0;
        end else if (r_state == ST_SHOW) begin
            if (w_next_press & w_prev_press) begin
                w_page_n = r_page;
            end else if (w_next_press) begin
                w_page_n = r_page + 3'd1;
            end else if (w_prev_press) begin
                w_page_n = r_page - 3'd1;
            end else if (w_tick) begin
                w_page_n = r_page + 3'd1;
            end else begin
                w_page_n = r_page;
            end
            // Any press restarts the interval. A tick that lands on a press is dropped.
            if (i_auto_en && !(w_next_press || w_prev_press) && (r_presc != PRESC_TOP)) begin
                w_presc_n = r_presc + PRESC_ONE;
            end else begin
                w_presc_n = '0;
            end
        end else begin
            w_data_n  = r_data;
            w_page_n  = r_page;
            w_presc_n = '0;
        end
    end

    // Output decode: selects the 16-bit slice for the page being entered.
    always_comb begin
        case (w_page_n)
            3'd0:    w_slice = w_data_n[127:112];
            3'd1:    w_slice = w_data_n[111:96];
            3'd2:    w_slice = w_data_n[95:80];
            3'd3:    w_slice = w_data_n[79:64];
            3'd4:    w_slice = w_data_n[63:48];
            3'd5:    w_slice = w_data_n[47:32];
            3'd6:    w_slice = w_data_n[31:16];
            3'd7:    w_slice = w_data_n[15:0];
            default: w_slice = 16'h0000;
        endcase
        if (w_state_n == ST_SHOW) begin
            w_digits_n = {4'h0, 1'b0, w_page_n, w_slice};
            w_blank_n  = 6'b100000;
            w_valid_n  = 1'b1;
        end else begin
            w_digits_n = 24'h000000;
            w_blank_n  = 6'b111111;
            w_valid_n  = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data   <= 128'd0;
            r_page   <= 3'd0;
            r_presc  <= '0;
            r_next_q <= 1'b0;
            r_prev_q <= 1'b0;
            r_digits <= 24'h000000;
            r_blank  <= 6'b111111;
            r_valid  <= 1'b0;
        end else begin
            r_data   <= w_data_n;
            r_page   <= w_page_n;
            r_presc  <= w_presc_n;
            r_next_q <= i_btn_next;
            r_prev_q <= i_btn_prev;
            r_digits <= w_digits_n;
            r_blank  <= w_blank_n;
            r_valid  <= w_valid_n;
        end
    end

    assign o_digits = r_digits;
    assign o_blank  = r_blank;
    assign o_page   = r_page;
    assign o_valid  = r_valid;

endmodule

// File: tb/tb_aes_hex_pager.sv
// -----------------------------------------------------------------------------
// Testbench for aes_hex_pager with TICK_DIV=4. The stimulus side queues the
// display expected after each clock edge. A separate monitor pops one entry per
// edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_aes_hex_pager;

    localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] D2 = 128'h0123456789ABCDEFFEDCBA9876543210;

    typedef struct packed {
        logic [23:0] digits;
        logic [5:0]  blank;
        logic [2:0]  page;
        logic        valid;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [127:0] data_in = 128'd0;
    logic         btn_next = 1'b0;
    logic         btn_prev = 1'b0;
    logic         auto_en = 1'b0;
    logic [23:0]  digits;
    logic [5:0]   blank;
    logic [2:0]   page;
    logic         valid;

    exp_t         q[$];
    logic [127:0] exp_data = 128'd0;
    int           vectors = 0;
    int           miscompares = 0;

    aes_hex_pager #(.TICK_DIV(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (load),
        .i_data_in  (data_in),
        .i_btn_next (btn_next),
        .i_btn_prev (btn_prev),
        .i_auto_en  (auto_en),
        .o_digits   (digits),
        .o_blank    (blank),
        .o_page     (page),
        .o_valid    (valid)
    );

    always #5 clk = ~clk;

    // Hex slice of page p: page 0 is the most significant 16 bits.
    function automatic logic [15:0] slice16(input logic [127:0] d, input logic [2:0] p);
        logic [127:0] t;
        int           sh;
        sh = 16 * (7 - int'(p));
        t  = d >> sh;
        return t[15:0];
    endfunction

    // Drives one cycle of inputs and queues the display expected after the next edge.
    task automatic step(input logic rs, input logic ld, input logic bn, input logic bp,
                        input logic ae, input logic [2:0] ep, input logic ev);
        exp_t e;
        @(negedge clk);
        rst      = rs;
        load     = ld;
        btn_next = bn;
        btn_prev = bp;
        auto_en  = ae;
        if (ld) exp_data = data_in;
        if (ev) begin
            e.digits = {4'h0, 1'b0, ep, slice16(exp_data, ep)};
            e.blank  = 6'h20;
            e.page   = ep;
            e.valid  = 1'b1;
        end else begin
            e.digits = 24'h000000;
            e.blank  = 6'h3F;
            e.page   = 3'd0;
            e.valid  = 1'b0;
        end
        q.push_back(e);
    endtask

    // Monitor: compares the outputs just after every rising edge that has an expectation queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if ({digits, blank, page, valid} !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d: got digits=%h blank=%h page=%0d valid=%b, expected digits=%h blank=%h page=%0d valid=%b",
                             vectors, digits, blank, page, valid, e.digits, e.blank, e.page, e.valid);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        data_in = D1;
        // 1: reset with buttons held, then release
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        // 2: load D1, page 0 = 24'h000011
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        // 3: seven next pulses reach page 7 (EEFF)
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'(i), 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'(i), 1'b1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);   // 7 -> 0
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b1);   // 0 -> 7
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);  // one step only
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        // 4: auto-scroll, one page per 4 cycles, wraps after page 7
        for (int k = 1; k <= 32; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'((k / 4) % 8), 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);   // count now 2
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1);   // press restarts the interval
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
        // 5: load, next and a due tick in the same cycle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
        data_in = D2;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1);   // both buttons: no change
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
        // 6: reset at page 5 while auto-scrolling
        for (int i = 2; i <= 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'(i), 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'(i), 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        data_in = D1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
